// File: rtl/csr_spmv_engine_pkg.sv
//==============================================================================
// Module      : spmv_pkg
// Description : Shared state encoding and default sizing for the CSR SpMV engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spmv_pkg;

    localparam int c_def_rows    = 4;
    localparam int c_def_cols    = 4;
    localparam int c_def_nnz_max = 16;
    localparam int c_def_val_w   = 8;
    localparam int c_def_acc_w   = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CSR = 3'd1,
        ST_LOAD_VEC = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_TRANSMIT = 3'd4
    } spmv_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_spmv_engine_if.sv
//==============================================================================
// Module      : csr_spmv_engine_if
// Description : Entry, spike-vector and result handshakes plus status of the engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface csr_spmv_engine_if
    import spmv_pkg::*;
#(
    parameter int ROWS  = c_def_rows,
    parameter int COLS  = c_def_cols,
    parameter int VAL_W = c_def_val_w,
    parameter int ACC_W = c_def_acc_w
) ();

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic             start;
    logic             ent_valid;
    logic             ent_ready;
    logic [RW-1:0]    ent_row;
    logic [CW-1:0]    ent_col;
    logic [VAL_W-1:0] ent_val;
    logic             ent_done;
    logic             vec_valid;
    logic             vec_ready;
    logic [COLS-1:0]  vec_data;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [RW-1:0]    res_row;
    logic             res_last;
    logic             busy;
    logic [2:0]       err;

    modport master (
        output start, ent_valid, ent_row, ent_col, ent_val, ent_done,
               vec_valid, vec_data, res_ready,
        input  ent_ready, vec_ready, res_valid, res_data, res_row, res_last,
               busy, err
    );

    modport slave (
        input  start, ent_valid, ent_row, ent_col, ent_val, ent_done,
               vec_valid, vec_data, res_ready,
        output ent_ready, vec_ready, res_valid, res_data, res_row, res_last,
               busy, err
    );

endinterface

`default_nettype wire

// File: rtl/csr_entry_mem.sv
//==============================================================================
// Module      : csr_entry_mem
// Description : {row,col,val} register file, one write port, asynchronous read.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module csr_entry_mem
    import spmv_pkg::*;
#(
    parameter int DEPTH = c_def_nnz_max,
    parameter int AW    = $clog2(c_def_nnz_max),
    parameter int RW    = $clog2(c_def_rows),
    parameter int CW    = $clog2(c_def_cols),
    parameter int VAL_W = c_def_val_w
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [RW-1:0]    wrow,
    input  wire logic [CW-1:0]    wcol,
    input  wire logic [VAL_W-1:0] wval,
    input  wire logic [AW-1:0]    raddr,
    output logic      [RW-1:0]    rrow,
    output logic      [CW-1:0]    rcol,
    output logic      [VAL_W-1:0] rval
);

    logic [RW-1:0]    r_row_mem [DEPTH];
    logic [CW-1:0]    r_col_mem [DEPTH];
    logic [VAL_W-1:0] r_val_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_row_mem[waddr] <= wrow;
            r_col_mem[waddr] <= wcol;
            r_val_mem[waddr] <= wval;
        end
    end

    assign rrow = r_row_mem[raddr];
    assign rcol = r_col_mem[raddr];
    assign rval = r_val_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/csr_spmv_engine.sv
//==============================================================================
// Module      : csr_spmv_engine
// Description : Sparse CSR matrix times binary spike vector, one entry or row per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module csr_spmv_engine
    import spmv_pkg::*;
#(
    parameter int ROWS    = c_def_rows,
    parameter int COLS    = c_def_cols,
    parameter int NNZ_MAX = c_def_nnz_max,
    parameter int VAL_W   = c_def_val_w,
    parameter int ACC_W   = c_def_acc_w
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    csr_spmv_engine_if.slave  bus
);

    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int IW        = $clog2(NNZ_MAX + 1);
    localparam int AW        = $clog2(NNZ_MAX);
    localparam int VEC_PAD_W = 1 << CW;

    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [RW-1:0]    LAST_ROW = RW'(ROWS - 1);
    localparam logic [IW-1:0]    CNT_MAX  = IW'(NNZ_MAX);

    spmv_state_e      r_state;
    logic [IW-1:0]    r_count;
    logic [IW-1:0]    r_idx;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_prev_row;
    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_err;
    logic [COLS-1:0]  r_vec;
    logic             r_ent_ready;
    logic             r_vec_ready;
    logic             r_res_valid;
    logic             r_res_last;
    logic             r_busy;
    logic [ACC_W-1:0] r_res_data;
    logic [RW-1:0]    r_res_row;
    logic [ACC_W-1:0] r_result [ROWS];

    logic                 w_ent_fire;
    logic                 w_ent_order_bad;
    logic                 w_we;
    logic [RW-1:0]        w_rd_row;
    logic [CW-1:0]        w_rd_col;
    logic [VAL_W-1:0]     w_rd_val;
    logic                 w_take;
    logic [VEC_PAD_W-1:0] w_vec_pad;
    logic                 w_col_oob;
    logic                 w_hit;
    logic [ACC_W:0]       w_sum;
    logic                 w_sat;
    logic [ACC_W-1:0]     w_acc_next;
    logic [ACC_W-1:0]     w_row0_data;
    logic [RW-1:0]        w_next_tx;

    // ent_done wins over a same-cycle entry, so the entry is never written.
    assign w_ent_fire      = bus.ent_valid & r_ent_ready & ~bus.ent_done;
    assign w_ent_order_bad = bus.ent_row < r_prev_row;
    assign w_we            = (r_state == ST_LOAD_CSR) & w_ent_fire & ~w_ent_order_bad;

    csr_entry_mem #(
        .DEPTH (NNZ_MAX),
        .AW    (AW),
        .RW    (RW),
        .CW    (CW),
        .VAL_W (VAL_W)
    ) u_entry_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_count[AW-1:0]),
        .wrow  (bus.ent_row),
        .wcol  (bus.ent_col),
        .wval  (bus.ent_val),
        .raddr (r_idx[AW-1:0]),
        .rrow  (w_rd_row),
        .rcol  (w_rd_col),
        .rval  (w_rd_val)
    );

    assign w_vec_pad = VEC_PAD_W'(r_vec);

    generate
        if (VEC_PAD_W > COLS) begin : g_col_chk
            assign w_col_oob = ({1'b0, w_rd_col} >= (CW + 1)'(COLS));
        end else begin : g_col_pow2
            assign w_col_oob = 1'b0;
        end
    endgenerate

    assign w_take      = (r_idx < r_count) && (w_rd_row == r_row);
    assign w_hit       = w_vec_pad[w_rd_col] & ~w_col_oob;
    assign w_sum       = {1'b0, r_acc} + (ACC_W + 1)'(w_rd_val);
    assign w_sat       = w_hit & w_sum[ACC_W];
    assign w_acc_next  = !w_hit ? r_acc : (w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0]);
    // Row 0's sum is still in the accumulator when ROWS is 1.
    assign w_row0_data = (r_row == '0) ? r_acc : r_result[0];
    assign w_next_tx   = r_row + RW'(1);

    always_ff @(posedge clk) begin
        if (r_state == ST_COMPUTE && !w_take) begin
            r_result[r_row] <= r_acc;
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_row       <= '0;
            r_prev_row  <= '0;
            r_acc       <= '0;
            r_err       <= '0;
            r_vec       <= '0;
            r_ent_ready <= 1'b0;
            r_vec_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_res_data  <= '0;
            r_res_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_LOAD_CSR;
                        r_count     <= '0;
                        r_err       <= '0;
                        r_prev_row  <= '0;
                        r_ent_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_LOAD_CSR: begin
                    if (bus.ent_done) begin
                        r_state     <= ST_LOAD_VEC;
                        r_ent_ready <= 1'b0;
                        r_vec_ready <= 1'b1;
                    end else if (w_ent_fire) begin
                        if (w_ent_order_bad) begin
                            r_err[0] <= 1'b1;
                        end else begin
                            r_count     <= r_count + IW'(1);
                            r_prev_row  <= bus.ent_row;
                            r_ent_ready <= (r_count + IW'(1)) < CNT_MAX;
                        end
                    end
                end
                ST_LOAD_VEC: begin
                    if (bus.vec_valid) begin
                        r_state     <= ST_COMPUTE;
                        r_vec       <= bus.vec_data;
                        r_vec_ready <= 1'b0;
                        r_idx       <= '0;
                        r_row       <= '0;
                        r_acc       <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (w_take) begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + IW'(1);
                        if (w_sat) begin
                            r_err[2] <= 1'b1;
                        end
                        if (w_col_oob) begin
                            r_err[1] <= 1'b1;
                        end
                    end else begin
                        r_acc <= '0;
                        if (r_row == LAST_ROW) begin
                            r_state     <= ST_TRANSMIT;
                            r_row       <= '0;
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_row0_data;
                            r_res_row   <= '0;
                            r_res_last  <= (ROWS == 1);
                        end else begin
                            r_row <= w_next_tx;
                        end
                    end
                end
                ST_TRANSMIT: begin
                    if (bus.res_ready) begin
                        if (r_res_last) begin
                            r_state     <= ST_IDLE;
                            r_res_valid <= 1'b0;
                            r_res_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_row      <= w_next_tx;
                            r_res_row  <= w_next_tx;
                            r_res_data <= r_result[w_next_tx];
                            r_res_last <= (w_next_tx == LAST_ROW);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ent_ready = r_ent_ready;
    assign bus.vec_ready = r_vec_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_row   = r_res_row;
    assign bus.res_last  = r_res_last;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_csr_spmv_engine.sv
//==============================================================================
// Module      : tb_csr_spmv_engine
// Description : Directed scenarios for csr_spmv_engine with hand-computed results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_csr_spmv_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    csr_spmv_engine_if #(.ROWS(4), .COLS(4), .VAL_W(8), .ACC_W(12)) if0 ();
    csr_spmv_engine_if #(.ROWS(4), .COLS(4), .VAL_W(8), .ACC_W(8))  if8 ();

    csr_spmv_engine #(.ROWS(4), .COLS(4), .NNZ_MAX(16), .VAL_W(8), .ACC_W(12)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    csr_spmv_engine #(.ROWS(4), .COLS(4), .NNZ_MAX(16), .VAL_W(8), .ACC_W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] obs_data [4];
    logic [1:0]  obs_row  [4];
    logic        obs_last [4];
    logic [7:0]  obs8_data [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if0.start = 0; if0.ent_valid = 0; if0.ent_row = '0; if0.ent_col = '0; if0.ent_val = '0;
        if0.ent_done = 0; if0.vec_valid = 0; if0.vec_data = '0; if0.res_ready = 0;
        if8.start = 0; if8.ent_valid = 0; if8.ent_row = '0; if8.ent_col = '0; if8.ent_val = '0;
        if8.ent_done = 0; if8.vec_valid = 0; if8.vec_data = '0; if8.res_ready = 0;
    endtask

    task automatic start0();
        if0.start = 1; tick(); if0.start = 0;
    endtask

    task automatic ent0(input int r, input int c, input int v);
        if0.ent_valid = 1; if0.ent_row = 2'(r); if0.ent_col = 2'(c); if0.ent_val = 8'(v);
        tick();
        if0.ent_valid = 0;
    endtask

    task automatic done0();
        if0.ent_done = 1; tick(); if0.ent_done = 0;
    endtask

    task automatic vec0(input logic [3:0] v);
        if0.vec_valid = 1; if0.vec_data = v; tick(); if0.vec_valid = 0;
    endtask

    task automatic wait_res0(output int n);
        n = 0;
        while (!if0.res_valid && n < 200) begin
            tick(); n++;
        end
    endtask

    task automatic drain0();
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            while (!if0.res_valid && w < 20) begin
                tick(); w++;
            end
            obs_data[k] = if0.res_valid ? if0.res_data : 12'hFFF;
            obs_row[k]  = if0.res_row;
            obs_last[k] = if0.res_last;
            if0.res_ready = 1; tick(); if0.res_ready = 0;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", if0.busy); end
        n_checks++; if (if0.ent_ready !== 1'b0 || if0.vec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b%0b want 00", if0.ent_ready, if0.vec_ready); end
        n_checks++; if (if0.res_valid !== 1'b0 || if0.res_last !== 1'b0) begin n_fail++; $display("FAIL reset_res_flags: got %0b%0b want 00", if0.res_valid, if0.res_last); end
        n_checks++; if (if0.res_data !== 12'd0 || if0.res_row !== 2'd0) begin n_fail++; $display("FAIL reset_res_word: got %0d/%0d want 0/0", if0.res_data, if0.res_row); end
        n_checks++; if (if0.err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", if0.err); end
        rst_n = 0;
        tick();
        n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0b want 0", if0.busy); end
    endtask

    task automatic test_basic();
        int n;
        logic [11:0] exp_d [4];
        exp_d = '{12'd8, 12'd0, 12'd0, 12'd2};
        start0();
        n_checks++; if (if0.busy !== 1'b1 || if0.ent_ready !== 1'b1) begin n_fail++; $display("FAIL basic_load_csr: busy/ent_ready got %0b%0b want 11", if0.busy, if0.ent_ready); end
        ent0(0, 0, 5); ent0(0, 2, 3); ent0(1, 1, 7); ent0(3, 3, 2);
        done0();
        n_checks++; if (if0.vec_ready !== 1'b1 || if0.ent_ready !== 1'b0) begin n_fail++; $display("FAIL basic_load_vec: vec/ent ready got %0b%0b want 10", if0.vec_ready, if0.ent_ready); end
        vec0(4'b1101);
        wait_res0(n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", n); end
        drain0();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (obs_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL basic_data row%0d: got %0d want %0d", k, obs_data[k], exp_d[k]); end
            n_checks++; if (obs_row[k] !== 2'(k) || obs_last[k] !== (k == 3)) begin n_fail++; $display("FAIL basic_row_last %0d: got row %0d last %0b", k, obs_row[k], obs_last[k]); end
        end
        n_checks++; if (if0.busy !== 1'b0 || if0.err !== 3'b000) begin n_fail++; $display("FAIL basic_end: busy/err got %0b/%b want 0/000", if0.busy, if0.err); end
    endtask

    task automatic test_empty();
        int n;
        start0(); done0(); vec0(4'hF);
        wait_res0(n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL empty_latency: got %0d want 4", n); end
        drain0();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (obs_data[k] !== 12'd0 || obs_last[k] !== (k == 3)) begin n_fail++; $display("FAIL empty_row%0d: got %0d last %0b want 0", k, obs_data[k], obs_last[k]); end
        end
    endtask

    task automatic test_full();
        int n;
        start0();
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (if0.ent_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready entry%0d: got %0b want 1", k, if0.ent_ready); end
            ent0(0, 0, 255);
        end
        n_checks++; if (if0.ent_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready entry16: got %0b want 0", if0.ent_ready); end
        ent0(0, 0, 255);
        done0(); vec0(4'b0001);
        wait_res0(n);
        n_checks++; if (n !== 20) begin n_fail++; $display("FAIL full_latency: got %0d want 20", n); end
        drain0();
        n_checks++; if (obs_data[0] !== 12'd4080) begin n_fail++; $display("FAIL full_row0: got %0d want 4080", obs_data[0]); end
        n_checks++; if (obs_data[1] !== 12'd0 || obs_data[3] !== 12'd0) begin n_fail++; $display("FAIL full_other_rows: got %0d/%0d want 0/0", obs_data[1], obs_data[3]); end
        n_checks++; if (if0.err !== 3'b000) begin n_fail++; $display("FAIL full_err: got %b want 000", if0.err); end
    endtask

    task automatic test_order();
        int n;
        start0();
        ent0(1, 0, 4); ent0(0, 0, 9);
        n_checks++; if (if0.err !== 3'b001) begin n_fail++; $display("FAIL order_err: got %b want 001", if0.err); end
        done0(); vec0(4'b0001);
        wait_res0(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL order_latency: got %0d want 5", n); end
        drain0();
        n_checks++; if (obs_data[0] !== 12'd0) begin n_fail++; $display("FAIL order_row0: got %0d want 0", obs_data[0]); end
        n_checks++; if (obs_data[1] !== 12'd4) begin n_fail++; $display("FAIL order_row1: got %0d want 4", obs_data[1]); end
        n_checks++; if (if0.err !== 3'b001) begin n_fail++; $display("FAIL order_err_sticky: got %b want 001", if0.err); end
    endtask

    task automatic test_saturate();
        int n;
        if8.start = 1; tick(); if8.start = 0;
        if8.ent_valid = 1; if8.ent_row = 2'd0; if8.ent_col = 2'd0; if8.ent_val = 8'd200; tick();
        if8.ent_col = 2'd1; if8.ent_val = 8'd100; tick();
        if8.ent_valid = 0;
        if8.ent_done = 1; tick(); if8.ent_done = 0;
        if8.vec_valid = 1; if8.vec_data = 4'b0011; tick(); if8.vec_valid = 0;
        n = 0;
        while (!if8.res_valid && n < 200) begin tick(); n++; end
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL sat_latency: got %0d want 6", n); end
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            while (!if8.res_valid && w < 20) begin tick(); w++; end
            obs8_data[k] = if8.res_valid ? if8.res_data : 8'hAA;
            if8.res_ready = 1; tick(); if8.res_ready = 0;
        end
        n_checks++; if (obs8_data[0] !== 8'd255) begin n_fail++; $display("FAIL sat_row0: got %0d want 255", obs8_data[0]); end
        n_checks++; if (obs8_data[2] !== 8'd0) begin n_fail++; $display("FAIL sat_row2: got %0d want 0", obs8_data[2]); end
        n_checks++; if (if8.err !== 3'b100) begin n_fail++; $display("FAIL sat_err: got %b want 100", if8.err); end
    endtask

    task automatic test_stall_reset();
        int n;
        start0();
        n_checks++; if (if0.err !== 3'b000) begin n_fail++; $display("FAIL stall_err_cleared: got %b want 000", if0.err); end
        ent0(0, 0, 5); ent0(0, 2, 3); ent0(1, 1, 7); ent0(3, 3, 2);
        done0(); vec0(4'b1101);
        wait_res0(n);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (if0.res_valid !== 1'b1 || if0.res_data !== 12'd8 || if0.res_row !== 2'd0 || if0.res_last !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold cycle%0d: got v%0b d%0d r%0d l%0b want v1 d8 r0 l0", k, if0.res_valid, if0.res_data, if0.res_row, if0.res_last);
            end
            tick();
        end
        #2 rst_n = 1;
        #1;
        n_checks++; if (if0.res_valid !== 1'b0 || if0.res_last !== 1'b0) begin n_fail++; $display("FAIL stall_rst_flags: got %0b%0b want 00", if0.res_valid, if0.res_last); end
        n_checks++; if (if0.res_data !== 12'd0 || if0.res_row !== 2'd0) begin n_fail++; $display("FAIL stall_rst_word: got %0d/%0d want 0/0", if0.res_data, if0.res_row); end
        n_checks++; if (if0.busy !== 1'b0 || if0.ent_ready !== 1'b0 || if0.vec_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rst_busy: got %0b%0b%0b want 000", if0.busy, if0.ent_ready, if0.vec_ready); end
        tick();
        rst_n = 0;
        tick();
        n_checks++; if (if0.busy !== 1'b0 || if0.err !== 3'b000) begin n_fail++; $display("FAIL stall_after: busy/err got %0b/%b want 0/000", if0.busy, if0.err); end
    endtask

    initial begin
        idle_inputs();
        #1 rst_n = 1;
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_order();
        test_saturate();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
